// File: rtl/tcp_loopback_stack_model.sv
// tcp_loopback_stack_model: TCP stack stand-in that acknowledges a TX command and loops its payload back through the RX path
module tcp_loopback_stack_model #(
  parameter int MAX_BEATS = 64,
  parameter int NOTIFY_DELAY = 4
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         s_axis_tx_metadata_valid,
  output logic         s_axis_tx_metadata_ready,
  input  logic [47:0]  s_axis_tx_metadata_data,
  input  logic         s_axis_tx_data_valid,
  output logic         s_axis_tx_data_ready,
  input  logic [511:0] s_axis_tx_data_data,
  input  logic [63:0]  s_axis_tx_data_keep,
  input  logic         s_axis_tx_data_last,
  output logic         m_axis_tx_status_valid,
  input  logic         m_axis_tx_status_ready,
  output logic [63:0]  m_axis_tx_status_data,
  output logic         m_axis_notifications_valid,
  input  logic         m_axis_notifications_ready,
  output logic [31:0]  m_axis_notifications_data,
  input  logic         s_axis_read_package_valid,
  output logic         s_axis_read_package_ready,
  input  logic [31:0]  s_axis_read_package_data,
  output logic         m_axis_rx_metadata_valid,
  input  logic         m_axis_rx_metadata_ready,
  output logic [15:0]  m_axis_rx_metadata_data,
  output logic         m_axis_rx_data_valid,
  input  logic         m_axis_rx_data_ready,
  output logic [511:0] m_axis_rx_data_data,
  output logic [63:0]  m_axis_rx_data_keep,
  output logic         m_axis_rx_data_last,
  output logic [127:0] status_reg
);
  localparam int AW = $clog2(MAX_BEATS);
  typedef enum logic [6:0] {
    IDLE = 7'h01, TX_DATA = 7'h02, TX_STATUS = 7'h04, NOTIFY = 7'h08,
    WAIT_READ = 7'h10, RX_META = 7'h20, RX_DATA = 7'h40
  } state_t;
  state_t st;
  logic [1:0] err;
  logic [15:0] sess;
  logic [31:0] len, lat, loops, last_lat, errs, md_len;
  logic [AW-1:0] lidx, wr_ptr, rd_ptr;
  logic rd_done, md_zero, md_over, wr_fin, rd_fin, rd_en, unused_keep;
  logic [7:0] dly;
  logic [511:0] mem [MAX_BEATS];
  assign md_len = s_axis_tx_metadata_data[47:16];
  assign md_zero = md_len == 32'd0;
  assign md_over = ((33'(md_len) + 33'd63) >> 6) > 33'(MAX_BEATS);
  assign wr_fin = wr_ptr == lidx;
  assign rd_fin = rd_ptr == lidx;
  assign rd_en = st == RX_DATA && (!m_axis_rx_data_valid || m_axis_rx_data_ready) && !rd_done;
  assign unused_keep = ^s_axis_tx_data_keep;
  assign s_axis_tx_metadata_ready = st == IDLE;
  assign s_axis_tx_data_ready = st == TX_DATA;
  assign m_axis_tx_status_valid = st == TX_STATUS;
  assign s_axis_read_package_ready = st == WAIT_READ;
  assign m_axis_rx_metadata_valid = st == RX_META;
  assign m_axis_tx_status_data = {err, 14'b0, len, sess};
  assign m_axis_notifications_data = {len[15:0], sess};
  assign m_axis_rx_metadata_data = sess;
  assign status_reg = {25'b0, st, errs, last_lat, loops};
  // Payload RAM is never reset; the read register doubles as the rx data output
  always_ff @(posedge clk) begin
    if (st == TX_DATA && s_axis_tx_data_valid) mem[wr_ptr] <= s_axis_tx_data_data;
    if (rd_en) m_axis_rx_data_data <= mem[rd_ptr];
  end
  always_ff @(posedge clk) begin
    if (!rstn) begin
      st <= IDLE;
      err <= 2'd0;
      sess <= 16'd0;
      len <= 32'd0;
      lidx <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      rd_done <= 1'b0;
      dly <= 8'd0;
      lat <= 32'd0;
      loops <= 32'd0;
      last_lat <= 32'd0;
      errs <= 32'd0;
      m_axis_notifications_valid <= 1'b0;
      m_axis_rx_data_valid <= 1'b0;
      m_axis_rx_data_keep <= '0;
      m_axis_rx_data_last <= 1'b0;
    end else begin
      lat <= lat + 32'd1;
      case (st)
        IDLE: if (s_axis_tx_metadata_valid) begin
          sess <= s_axis_tx_metadata_data[15:0];
          len <= md_len;
          lidx <= AW'((md_len - 32'd1) >> 6);
          wr_ptr <= '0;
          lat <= 32'd1;
          err <= md_zero ? 2'd1 : md_over ? 2'd2 : 2'd0;
          st <= (md_zero || md_over) ? TX_STATUS : TX_DATA;
        end
        TX_DATA: if (s_axis_tx_data_valid) begin
          wr_ptr <= wr_ptr + AW'(1);
          if (s_axis_tx_data_last || wr_fin) begin
            err <= (s_axis_tx_data_last && wr_fin) ? 2'd0 : 2'd3;
            st <= TX_STATUS;
          end
        end
        TX_STATUS: if (m_axis_tx_status_ready) begin
          errs <= errs + 32'(err != 2'd0);
          dly <= 8'(NOTIFY_DELAY - 1);
          m_axis_notifications_valid <= err == 2'd0 && NOTIFY_DELAY == 1;
          st <= err != 2'd0 ? IDLE : NOTIFY;
        end
        NOTIFY: if (!m_axis_notifications_valid) begin
          dly <= dly - 8'd1;
          m_axis_notifications_valid <= dly == 8'd1;
        end else if (m_axis_notifications_ready) begin
          m_axis_notifications_valid <= 1'b0;
          st <= WAIT_READ;
        end
        WAIT_READ: if (s_axis_read_package_valid) begin
          errs <= errs + 32'(s_axis_read_package_data != {len[15:0], sess});
          st <= RX_META;
        end
        RX_META: if (m_axis_rx_metadata_ready) begin
          rd_ptr <= '0;
          rd_done <= 1'b0;
          st <= RX_DATA;
        end
        RX_DATA: if (m_axis_rx_data_valid && m_axis_rx_data_ready && m_axis_rx_data_last) begin
          m_axis_rx_data_valid <= 1'b0;
          m_axis_rx_data_last <= 1'b0;
          loops <= loops + 32'd1;
          last_lat <= lat + 32'd1;
          st <= IDLE;
        end else if (rd_en) begin
          m_axis_rx_data_valid <= 1'b1;
          m_axis_rx_data_last <= rd_fin;
          m_axis_rx_data_keep <= (rd_fin && len[5:0] != 6'd0) ? (64'd1 << len[5:0]) - 64'd1 : '1;
          rd_ptr <= rd_ptr + AW'(1);
          rd_done <= rd_fin;
        end else if (m_axis_rx_data_ready) begin
          m_axis_rx_data_valid <= 1'b0;
        end
        default: st <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_tcp_loopback_stack_model.sv
// tb_tcp_loopback_stack_model: directed and random loopback transactions checked against a transaction-level model
module tb_tcp_loopback_stack_model;
  localparam int MAXB = 64;
  localparam int DLY = 4;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic md_valid = 1'b0, md_ready;
  logic [47:0] md_data = '0;
  logic d_valid = 1'b0, d_ready, d_last = 1'b0;
  logic [511:0] d_data = '0;
  logic [63:0] d_keep = '0;
  logic st_valid, st_ready = 1'b0;
  logic [63:0] st_data;
  logic n_valid, n_ready = 1'b0;
  logic [31:0] n_data;
  logic rp_valid = 1'b0, rp_ready;
  logic [31:0] rp_data = '0;
  logic rm_valid, rm_ready = 1'b0;
  logic [15:0] rm_data;
  logic r_valid, r_ready = 1'b0, r_last;
  logic [511:0] r_data;
  logic [63:0] r_keep;
  logic [127:0] status_reg;
  int cyc = 0;
  int n_chk = 0, n_pass = 0, m_loops = 0, m_errs = 0;
  logic [511:0] pay[$];
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  tcp_loopback_stack_model #(.MAX_BEATS(MAXB), .NOTIFY_DELAY(DLY)) dut (
    .clk(clk), .rstn(rstn),
    .s_axis_tx_metadata_valid(md_valid), .s_axis_tx_metadata_ready(md_ready), .s_axis_tx_metadata_data(md_data),
    .s_axis_tx_data_valid(d_valid), .s_axis_tx_data_ready(d_ready), .s_axis_tx_data_data(d_data),
    .s_axis_tx_data_keep(d_keep), .s_axis_tx_data_last(d_last),
    .m_axis_tx_status_valid(st_valid), .m_axis_tx_status_ready(st_ready), .m_axis_tx_status_data(st_data),
    .m_axis_notifications_valid(n_valid), .m_axis_notifications_ready(n_ready), .m_axis_notifications_data(n_data),
    .s_axis_read_package_valid(rp_valid), .s_axis_read_package_ready(rp_ready), .s_axis_read_package_data(rp_data),
    .m_axis_rx_metadata_valid(rm_valid), .m_axis_rx_metadata_ready(rm_ready), .m_axis_rx_metadata_data(rm_data),
    .m_axis_rx_data_valid(r_valid), .m_axis_rx_data_ready(r_ready), .m_axis_rx_data_data(r_data),
    .m_axis_rx_data_keep(r_keep), .m_axis_rx_data_last(r_last),
    .status_reg(status_reg)
  );
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [599:0] obs, input logic [599:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask
  function automatic logic [511:0] rnd512();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction
  function automatic logic [63:0] exp_keep(input int idx, input longint beats, input int rem);
    logic [63:0] k;
    for (int b = 0; b < 64; b++) k[b] = (idx != beats - 1) || (rem == 0) || (b < rem);
    return k;
  endfunction
  task automatic do_reset;
    rstn = 1'b0;
    md_valid = 1'b0; d_valid = 1'b0; d_last = 1'b0; st_ready = 1'b0;
    n_ready = 1'b0; rp_valid = 1'b0; rm_ready = 1'b0; r_ready = 1'b0;
    step;
    chk("rst_valids", {st_valid, n_valid, rm_valid, r_valid}, 4'b0000);
    chk("rst_readies", {md_ready, d_ready, rp_ready}, 3'b100);
    chk("rst_status", status_reg, {32'd1, 96'd0});
    rstn = 1'b1;
    step;
    m_loops = 0;
    m_errs = 0;
  endtask
  // One full command/payload/status/notify/read/rx exchange; abort_at >= 0 resets mid-RX
  task automatic txn(input logic [31:0] len, input logic [15:0] sess, input int last_at, input int rdy_pct,
                     input bit incr, input logic [31:0] rp_word, input int abort_at);
    longint beats = (longint'(len) + 63) / 64;
    int err, n_send, t0, ts, t1, k, idx;
    logic held, seen;
    logic [599:0] hv;
    err = len == 0 ? 1 : beats > MAXB ? 2 : 0;
    n_send = 0;
    if (err == 0) begin
      n_send = (last_at < beats - 1) ? last_at + 1 : int'(beats);
      if (last_at != beats - 1) err = 3;
    end
    pay.delete();
    t1 = 0;
    md_data = {len, sess};
    md_valid = 1'b1;
    k = 0;
    while (!md_ready && k < 50) begin step; k++; end
    chk("md_ready", md_ready, 1);
    t0 = cyc;
    step;
    md_valid = 1'b0;
    for (int i = 0; i < n_send; i++) begin
      d_data = incr ? 512'(i) : rnd512();
      d_keep = {$urandom, $urandom};
      d_last = i == last_at;
      d_valid = 1'b1;
      k = 0;
      while (!d_ready && k < 50) begin step; k++; end
      chk("d_ready", d_ready, 1);
      pay.push_back(d_data);
      step;
    end
    d_valid = 1'b0;
    d_last = 1'b0;
    chk("d_ready_low", d_ready, 0);
    k = 0;
    while (!st_valid && k < 50) begin step; k++; end
    chk("status", st_data, {2'(err), 14'b0, len, sess});
    st_ready = 1'b1;
    ts = cyc;
    step;
    st_ready = 1'b0;
    if (err != 0) begin
      m_errs++;
      chk("err_idle", status_reg[127:96], 1);
      chk("err_count", status_reg[95:64], m_errs);
      seen = 1'b0;
      repeat (8) begin seen |= n_valid | d_ready; step; end
      chk("err_no_notify", seen, 0);
      return;
    end
    k = 0;
    while (!n_valid && k < 300) begin step; k++; end
    chk("notify_delay", cyc - ts, DLY);
    chk("notify", n_data, {len[15:0], sess});
    n_ready = 1'b1;
    step;
    n_ready = 1'b0;
    rp_data = rp_word;
    rp_valid = 1'b1;
    k = 0;
    while (!rp_ready && k < 50) begin step; k++; end
    chk("rp_ready", rp_ready, 1);
    step;
    rp_valid = 1'b0;
    if (rp_word != {len[15:0], sess}) m_errs++;
    k = 0;
    while (!rm_valid && k < 50) begin step; k++; end
    chk("rx_meta", {rm_valid, rm_data}, {1'b1, sess});
    rm_ready = 1'b1;
    step;
    rm_ready = 1'b0;
    idx = 0;
    k = 0;
    held = 1'b0;
    hv = '0;
    while (idx < beats && k < int'(beats) * 40 + 100) begin
      if (abort_at == idx) begin
        do_reset();
        return;
      end
      r_ready = int'($urandom_range(99)) < rdy_pct;
      if (held) chk("rx_hold", {r_valid, r_last, r_keep, r_data}, hv);
      held = r_valid && !r_ready;
      hv = {r_valid, r_last, r_keep, r_data};
      if (r_valid && r_ready) begin
        chk("rx_data", r_data, pay[idx]);
        chk("rx_keep", r_keep, exp_keep(idx, beats, int'(len % 64)));
        chk("rx_last", r_last, idx == beats - 1);
        if (idx == beats - 1) t1 = cyc;
        idx++;
      end
      step;
      k++;
    end
    r_ready = 1'b0;
    chk("rx_count", idx, beats);
    chk("rx_no_extra", r_valid, 0);
    m_loops++;
    chk("loops", status_reg[31:0], m_loops);
    chk("latency", status_reg[63:32], t1 - t0 + 1);
    chk("errs", status_reg[95:64], m_errs);
    chk("idle", status_reg[127:96], 1);
  endtask
  initial begin
    logic [31:0] len;
    logic [15:0] sess;
    do_reset();
    txn(32'd128, 16'd5, 1, 100, 1'b0, 32'h0080_0005, -1);
    txn(32'd100, 16'd7, 1, 100, 1'b0, {16'd100, 16'd7}, -1);
    txn(32'd0, 16'd9, 0, 100, 1'b0, 32'd0, -1);
    txn(32'd4097, 16'd10, 64, 100, 1'b0, 32'd0, -1);
    chk("two_errs", status_reg[95:64], 2);
    txn(32'd192, 16'd11, 1, 100, 1'b0, 32'd0, -1);
    txn(32'd64, 16'd12, 0, 100, 1'b0, {16'd64, 16'd12}, -1);
    txn(32'd256, 16'd13, 3, 100, 1'b0, 32'hdead_beef, -1);
    txn(32'd4096, 16'd14, 63, 50, 1'b1, {16'd4096, 16'd14}, -1);
    for (int i = 0; i < 6; i++) begin
      len = $urandom_range(1, 4300);
      sess = 16'($urandom);
      txn(len, sess, int'((len + 63) / 64) - 1, int'($urandom_range(30, 100)), 1'b0, {len[15:0], sess}, -1);
    end
    txn(32'd256, 16'd20, 3, 100, 1'b0, {16'd256, 16'd20}, 1);
    txn(32'd64, 16'd21, 0, 100, 1'b0, {16'd64, 16'd21}, -1);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
  initial begin
    #2ms;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1);
  end
endmodule
